// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: PC-select codes, fetch FSM
// states and the default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/npc.sv
// Next-PC arithmetic: sequential, PC-relative branch, pseudo-direct jump and
// register jump. Purely combinational so a pipelined core can reuse it.
module npc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] br_offset_s;

  assign br_offset_s = {{14{imm[15]}}, imm, 2'b00};

  // Select the next PC source.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = pc_plus4 + br_offset_s;
      PC_J:    next_pc = {pc_plus4[31:28], instr_index, 2'b00};
      PC_JR:   next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake,
// holds the word until consumed and traps on a misaligned target.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] idata,
  output logic        idata_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        consume,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic        fault
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  idata_r;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  next_pc_s;

  assign pc_plus4_s = pc_r + 32'd4;

  npc u_npc (
    .pc_plus4    (pc_plus4_s),
    .pc_sel      (pc_sel),
    .imm         (imm),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .next_pc     (next_pc_s)
  );

  // Fetch FSM with PC and instruction holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      idata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            idata_r <= imem_rdata;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (consume) begin
            // A misaligned target leaves pc on the offending instruction.
            if (is_word_aligned(next_pc_s)) begin
              pc_r    <= next_pc_s;
              state_r <= ST_FETCH;
            end else begin
              state_r <= ST_FAULT;
            end
          end
        end
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode only the state register, so reset
  // clears them asynchronously and no input reaches them combinationally.
  assign imem_req    = (state_r == ST_FETCH);
  assign idata_valid = (state_r == ST_HOLD);
  assign fault       = (state_r == ST_FAULT);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign idata       = idata_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: expected fetch addresses are queued
// when a consume is driven and popped when the DUT issues its next request.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] idata;
  logic        idata_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        consume;
  logic [1:0]  pc_sel;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic        fault;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_m;
  logic [31:0] last_data;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .idata       (idata),
    .idata_valid (idata_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .consume     (consume),
    .pc_sel      (pc_sel),
    .imm         (imm),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_pc"},    pc,                   RST_PC);
    chk({tag, "_pc4"},   pc_plus4,             RST_PC + 32'd4);
    chk({tag, "_idata"}, idata,                32'd0);
    chk({tag, "_valid"}, {31'd0, idata_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault},       32'd0);
  endtask

  task automatic fetch(input int waits);
    logic [31:0] exp;
    wait_req();
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
      exp = pc_m;
    end else begin
      exp = exp_q.pop_front();
    end
    chk("imem_addr",   imem_addr,            exp);
    chk("pc_fetch",    pc,                   exp);
    chk("pc_plus4",    pc_plus4,             exp + 32'd4);
    chk("valid_fetch", {31'd0, idata_valid}, 32'd0);
    repeat (waits) @(negedge clk);
    chk("req_held", {31'd0, imem_req}, 32'd1);
    imem_rdata = mem_word(exp);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    last_data  = mem_word(exp);
    chk("valid_rise", {31'd0, idata_valid}, 32'd1);
    chk("idata",      idata,                last_data);
    chk("req_drop",   {31'd0, imem_req},    32'd0);
  endtask

  task automatic do_consume(input logic [1:0] s, input logic [15:0] im, input logic [25:0] ix,
                            input logic [31:0] jr, input logic [31:0] exp_pc, input logic exp_fault);
    consume     = 1'b1;
    pc_sel      = s;
    imm         = im;
    instr_index = ix;
    jr_target   = jr;
    @(negedge clk);
    consume     = 1'b0;
    pc_sel      = 2'($urandom);
    imm         = 16'($urandom);
    instr_index = 26'($urandom);
    jr_target   = $urandom;
    if (!exp_fault) begin
      chk("pc_next",    pc,                   exp_pc);
      chk("valid_drop", {31'd0, idata_valid}, 32'd0);
      chk("req_rise",   {31'd0, imem_req},    32'd1);
      exp_q.push_back(exp_pc);
      pc_m = exp_pc;
    end else begin
      chk("fault_set",   {31'd0, fault},       32'd1);
      chk("fault_req",   {31'd0, imem_req},    32'd0);
      chk("fault_pc",    pc,                   pc_m);
      chk("fault_valid", {31'd0, idata_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; consume = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    pc_sel = 2'b00; imm = 16'd0; instr_index = 26'd0; jr_target = 32'd0;
    pc_m = RST_PC; last_data = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    exp_q.push_back(RST_PC);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Sequential, branch, jump, register jump.
    fetch(2);
    do_consume(2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3004, 1'b0);
    fetch(0);
    do_consume(2'b11, 16'h0000, 26'h0, 32'h0000_3010, 32'h0000_3010, 1'b0);
    fetch(1);
    do_consume(2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_300C, 1'b0);
    fetch(0);
    do_consume(2'b11, 16'h0000, 26'h0, 32'h0000_3020, 32'h0000_3020, 1'b0);
    fetch(0);
    do_consume(2'b10, 16'h0000, 26'h0000C40, 32'h0, 32'h0000_3100, 1'b0);
    fetch(0);
    do_consume(2'b11, 16'h0000, 26'h0, 32'h0000_3200, 32'h0000_3200, 1'b0);

    // consume during FETCH and imem_ready during HOLD are ignored.
    wait_req();
    consume = 1'b1; pc_sel = 2'b11; jr_target = 32'h0000_0100;
    @(negedge clk);
    consume = 1'b0;
    chk("viol_fetch_pc",  pc,                32'h0000_3200);
    chk("viol_fetch_req", {31'd0, imem_req}, 32'd1);
    fetch(1);
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("viol_hold_idata", idata,                last_data);
    chk("viol_hold_valid", {31'd0, idata_valid}, 32'd1);
    chk("viol_hold_pc",    pc,                   32'h0000_3200);

    // Wrap-around from the top of the address space.
    do_consume(2'b11, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch(0);
    do_consume(2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 1'b0);
    fetch(0);

    // Misaligned register jump traps; FAULT is sticky.
    do_consume(2'b11, 16'h0000, 26'h0, 32'h0000_3202, 32'h0, 1'b1);
    consume = 1'b1; imem_ready = 1'b1; pc_sel = 2'b00;
    repeat (3) @(negedge clk);
    consume = 1'b0; imem_ready = 1'b0;
    chk("fault_sticky", {31'd0, fault},    32'd1);
    chk("fault_noreq",  {31'd0, imem_req}, 32'd0);
    chk("fault_pc_hold", pc,               32'h0000_0000);

    // Reset out of FAULT.
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_fault");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_q.push_back(RST_PC); pc_m = RST_PC;
    fetch(0);
    do_consume(2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3004, 1'b0);

    // Asynchronous reset in the middle of a FETCH handshake.
    wait_req();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_fetch");
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b0; imem_ready = 1'b0;
    exp_q.delete(); exp_q.push_back(RST_PC); pc_m = RST_PC;
    chk("rst_idle_req", {31'd0, imem_req}, 32'd0);
    fetch(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
